// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache request interface.
// Fixed-latency single-word read/write backing store.
module cache_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_req_addr,
    input  logic        mem_req_vaild,
    input  logic        mem_req_wr,
    input  logic [31:0] mem_wr_data,
    output logic        mem_req_ready,
    output logic [31:0] mem_req_data,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

    state_t                state;
    state_t                state_nx;
    logic [7:0]            lat_cnt;
    logic [7:0]            lat_nx;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  wr_q;
    logic [31:0]           wdata_q;
    logic                  load;
    logic                  rd_load;

    logic [31:0] mem [DEPTH] = '{default: '0};

    logic unused_addr;
    assign unused_addr = ^{mem_req_addr[31:DEPTH_LOG2+2], mem_req_addr[1:0]};

    assign req_idx = mem_req_addr[DEPTH_LOG2+1:2];

    always_comb begin
        state_nx = state;
        lat_nx   = lat_cnt;
        load     = 1'b0;
        rd_load  = 1'b0;
        rd_idx   = idx;
        unique case (state)
            IDLE: begin
                if (mem_req_vaild) begin
                    load   = 1'b1;
                    lat_nx = 8'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                        rd_load  = ~mem_req_wr;
                        rd_idx   = req_idx;
                    end else begin
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                lat_nx = lat_cnt - 8'd1;
                if (lat_cnt == 8'd1) begin
                    state_nx = RESP;
                    rd_load  = ~wr_q;
                end
            end
            RESP: state_nx = DRAIN;
            DRAIN: begin
                if (!mem_req_vaild) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            idx           <= '0;
            wr_q          <= 1'b0;
            wdata_q       <= '0;
            mem_req_ready <= 1'b0;
            mem_req_data  <= '0;
            rd_count      <= '0;
            wr_count      <= '0;
        end else begin
            state         <= state_nx;
            lat_cnt       <= lat_nx;
            mem_req_ready <= (state_nx == RESP);
            if (load) begin
                idx     <= req_idx;
                wr_q    <= mem_req_wr;
                wdata_q <= mem_wr_data;
            end
            if (rd_load) mem_req_data <= mem[rd_idx];
            if (state == RESP) begin
                if (wr_q) begin
                    if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                end else begin
                    if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                end
            end
        end
    end

    // Reset forces state to IDLE, so an in-flight write never commits.
    always_ff @(posedge clk) begin
        if (state == RESP && wr_q) mem[idx] <= wdata_q;
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder.
// Scoreboard of expected read data plus a reference memory model.
module tb_cache_mem_responder;

    localparam int DL2 = 10;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic        valid = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic        ready;
    logic [31:0] data;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_rd = 0;
    int exp_wr = 0;
    logic [31:0] last_read = '0;
    logic [31:0] model [int];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    cache_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .mem_req_addr(addr),
        .mem_req_vaild(valid),
        .mem_req_wr(wr),
        .mem_wr_data(wdata),
        .mem_req_ready(ready),
        .mem_req_data(data),
        .rd_count(rd_count),
        .wr_count(wr_count)
    );

    function automatic int widx(input logic [31:0] a);
        logic [31:0] m;
        m = a >> 2;
        return int'(m & ((32'd1 << DL2) - 1));
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model.exists(widx(a))) return model[widx(a)];
        return 32'h0;
    endfunction

    task automatic issue(input logic [31:0] a, input logic w,
                         input logic [31:0] d, input int hold,
                         output int lat, output int extra,
                         output logic [31:0] rdata, output time t_rdy);
        lat = 0;
        extra = 0;
        rdata = '0;
        t_rdy = 0;
        @(negedge clk);
        addr = a;
        wr = w;
        wdata = d;
        valid = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (ready) begin
                lat = i;
                rdata = data;
                t_rdy = $time;
                break;
            end
        end
        for (int j = 1; j <= hold; j++) begin
            @(negedge clk);
            if (ready) extra++;
            if (j == hold) valid = 1'b0;
        end
        valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input string nm, output time t);
        int lat;
        int extra;
        logic [31:0] rd;
        issue(a, 1'b1, d, 1, lat, extra, rd, t);
        model[widx(a)] = d;
        exp_wr++;
        n_checks++;
        if (lat !== LAT) begin
            n_errors++;
            $display("FAIL %s_wr_latency got %0d want %0d", nm, lat, LAT);
        end
        n_checks++;
        if (data !== last_read) begin
            n_errors++;
            $display("FAIL %s_wr_data_hold got %h want %h", nm, data, last_read);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input string nm,
                           input int hold, output time t, output int extra);
        int lat;
        logic [31:0] rd;
        logic [31:0] exp;
        sb.push_back(model_rd(a));
        issue(a, 1'b0, 32'h0, hold, lat, extra, rd, t);
        exp = sb.pop_front();
        last_read = exp;
        exp_rd++;
        n_checks++;
        if (lat !== LAT) begin
            n_errors++;
            $display("FAIL %s_rd_latency got %0d want %0d", nm, lat, LAT);
        end
        n_checks++;
        if (rd !== exp) begin
            n_errors++;
            $display("FAIL %s_rd_data got %h want %h", nm, rd, exp);
        end
    endtask

    task automatic check_counts(input string nm);
        n_checks++;
        if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
            n_errors++;
            $display("FAIL %s_counts got rd=%0d wr=%0d want rd=%0d wr=%0d",
                     nm, rd_count, wr_count, exp_rd, exp_wr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs got ready=%b data=%h want 0 0", ready, data);
        end
        check_counts("reset");
        rst = 1'b1;
    endtask

    task automatic test_read_basic();
        time t;
        int extra;
        do_read(32'h0000_0100, "basic", 1, t, extra);
        n_checks++;
        if (extra !== 0) begin
            n_errors++;
            $display("FAIL basic_pulse_width got extra=%0d want 0", extra);
        end
        check_counts("basic");
    endtask

    task automatic test_write_read_offset();
        time t;
        int extra;
        do_write(32'h40, 32'hDEAD_BEEF, "offset", t);
        do_read(32'h43, "offset", 1, t, extra);
        check_counts("offset");
    endtask

    task automatic test_alias();
        time t;
        int extra;
        do_write(32'h0, 32'h1234_5678, "alias", t);
        do_read(32'h1000, "alias", 1, t, extra);
        check_counts("alias");
    endtask

    task automatic test_back_to_back();
        time t0;
        time t1;
        int extra;
        do_write(32'h80, 32'hA5A5_A5A5, "b2b", t0);
        do_read(32'h80, "b2b", 1, t1, extra);
        n_checks++;
        if (t1 - t0 !== time'((LAT + 2) * 10)) begin
            n_errors++;
            $display("FAIL b2b_spacing got %0t want %0d", t1 - t0, (LAT + 2) * 10);
        end
        check_counts("b2b");
    endtask

    task automatic test_hold_valid();
        time t;
        int extra;
        do_read(32'h40, "hold", 3, t, extra);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_errors++;
            $display("FAIL hold_extra_pulse got %0d want 0", extra);
        end
        check_counts("hold");
    endtask

    task automatic test_reset_midbusy();
        time t;
        int extra;
        int seen;
        seen = 0;
        @(negedge clk);
        addr = 32'h20;
        wr = 1'b1;
        wdata = 32'hFFFF_FFFF;
        valid = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL rstbusy_ready got %0d pulses want 0", seen);
        end
        exp_rd = 0;
        exp_wr = 0;
        last_read = 32'h0;
        check_counts("rstbusy_in_reset");
        rst = 1'b1;
        do_read(32'h20, "rstbusy", 1, t, extra);
        check_counts("rstbusy");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_write_read_offset();
        test_alias();
        test_back_to_back();
        test_hold_valid();
        test_reset_midbusy();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
